// File: rtl/audioport_pkg.sv
// audioport_pkg: shared types, widths and helpers for the audioport blocks.
// Holds the i2s_unit state enum, frame length and the rate-code divider lookup.
package audioport_pkg;

    localparam int unsigned AUDIO_BITS     = 24;
    localparam int unsigned I2S_FRAME_BITS = 2 * AUDIO_BITS;
    localparam int unsigned BIT_CNT_W      = 6;
    localparam int unsigned DIV_W          = 6;
    localparam int unsigned CFG_W          = 32;

    // [0] = left, [1] = right, two's complement
    typedef logic [1:0][AUDIO_BITS-1:0] stereo_t;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        PLAY = 2'd1,
        TAIL = 2'd2
    } i2s_state_t;

    // Rate code to mclk cycles per sck period
    function automatic logic [DIV_W-1:0] sck_div(input logic [1:0] rate);
        logic [DIV_W-1:0] n;
        case (rate)
            2'b00:   n = DIV_W'(4);
            2'b01:   n = DIV_W'(8);
            2'b10:   n = DIV_W'(16);
            default: n = DIV_W'(32);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/i2s_unit_if.sv
// i2s_unit_if: bus between cdc_unit (master) and i2s_unit (slave).
//   play_in, tick_in, audio_in, cfg_in, cfg_reg_in : master -> slave
//   req_out, sck_out, ws_out, sdo_out               : slave -> master / pads
interface i2s_unit_if;
    import audioport_pkg::*;

    logic             play_in;
    logic             tick_in;
    stereo_t          audio_in;
    logic             cfg_in;
    logic [CFG_W-1:0] cfg_reg_in;
    logic             req_out;
    logic             sck_out;
    logic             ws_out;
    logic             sdo_out;

    modport master (
        output play_in, tick_in, audio_in, cfg_in, cfg_reg_in,
        input  req_out, sck_out, ws_out, sdo_out
    );

    modport slave (
        input  play_in, tick_in, audio_in, cfg_in, cfg_reg_in,
        output req_out, sck_out, ws_out, sdo_out
    );

endinterface

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen: divides mclk by N (from the rate code) into the serial bit clock.
// Ports: mclk, mrst_n; run (hold cleared when 0); rate (2-bit code);
//        sck (registered, low N/2 then high N/2); rise_c / fall_c (strobes high
//        in the mclk cycle whose closing edge raises / drops sck).
module i2s_sck_gen
    import audioport_pkg::*;
(
    input  logic       mclk,
    input  logic       mrst_n,
    input  logic       run,
    input  logic [1:0] rate,
    output logic       sck,
    output logic       rise_c,
    output logic       fall_c
);

    localparam int unsigned CNT_W = DIV_W - 1;

    logic [DIV_W-1:0] n_c;
    logic [CNT_W-1:0] last_c;
    logic [CNT_W-1:0] half_last_c;
    logic [CNT_W-1:0] cnt;

    assign n_c         = sck_div(rate);
    assign last_c      = CNT_W'(n_c - DIV_W'(1));
    assign half_last_c = CNT_W'(n_c[DIV_W-1:1] - CNT_W'(1));
    assign rise_c      = run && (cnt == half_last_c);
    assign fall_c      = run && (cnt == last_c);

    // Position within the sck period; cleared while stopped so PLAY starts low
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= fall_c ? '0 : cnt + CNT_W'(1);
            if (rise_c)
                sck <= 1'b1;
            else if (fall_c)
                sck <= 1'b0;
        end
    end

endmodule

// File: rtl/i2s_unit.sv
// i2s_unit: I2S-style serial audio transmitter in the mclk domain.
// Ports: mclk, mrst_n (async active-low); bus (i2s_unit_if.slave) carrying
//        play/tick/audio/cfg inputs and req/sck/ws/sdo outputs.
// Build option: I2S_STANDARD_EN selects standard I2S (data one sck late,
//               TAIL period on stop); otherwise left-justified.
module i2s_unit
    import audioport_pkg::*;
(
    input  logic        mclk,
    input  logic        mrst_n,
    i2s_unit_if.slave   bus
);

`ifdef I2S_STANDARD_EN
    localparam bit I2S_STD = 1'b1;
`else
    localparam bit I2S_STD = 1'b0;
`endif

    localparam int unsigned          SH_W      = I2S_FRAME_BITS;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(I2S_FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] RIGHT_BIT = BIT_CNT_W'(AUDIO_BITS);

    i2s_state_t           state, state_d;
    logic [BIT_CNT_W-1:0] bcnt, bcnt_d, bcnt_inc_c;
    stereo_t              smp, smp_d;
    logic [SH_W-1:0]      sh, sh_d, frame_c;
    logic [1:0]           rate, rate_d;
    logic                 sdo, sdo_d, ws, ws_d, req, req_d;
    logic                 sck, rise_c, fall_c, run_c;
    logic                 cfg_unused_c;

    assign cfg_unused_c = ^bus.cfg_reg_in[CFG_W-1:2];
    assign frame_c      = {smp[0], smp[1]};
    assign bcnt_inc_c   = bcnt + BIT_CNT_W'(1);
    assign run_c        = (state != STOP);

    i2s_sck_gen u_sck_gen (
        .mclk   (mclk),
        .mrst_n (mrst_n),
        .run    (run_c),
        .rate   (rate),
        .sck    (sck),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // State register
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n)
            state <= STOP;
        else
            state <= state_d;
    end

    // Next state and datapath. The shift register advances on sck rise so its
    // MSB already holds the next bit when sck falls and sdo is updated.
    always_comb begin
        state_d = state;
        bcnt_d  = bcnt;
        smp_d   = smp;
        sh_d    = sh;
        rate_d  = rate;
        sdo_d   = sdo;
        ws_d    = ws;
        req_d   = 1'b0;

        // Nonblocking load keeps a coincident frame start on the old sample
        if (bus.tick_in)
            smp_d = bus.audio_in;

        unique case (state)
            STOP: begin
                bcnt_d = '0;
                sdo_d  = 1'b0;
                ws_d   = 1'b0;
                if (bus.cfg_in)
                    rate_d = bus.cfg_reg_in[1:0];
                if (bus.play_in) begin
                    state_d = PLAY;
                    req_d   = 1'b1;
                    sh_d    = frame_c;
                    sdo_d   = I2S_STD ? 1'b0 : frame_c[SH_W-1];
                end
            end
            PLAY: begin
                // In I2S mode bit 0 carries the previous LSB, so hold the MSB one period
                if (rise_c && !(I2S_STD && bcnt == '0))
                    sh_d = {sh[SH_W-2:0], 1'b0};
                if (fall_c) begin
                    if (bcnt == LAST_BIT) begin
                        bcnt_d = '0;
                        ws_d   = 1'b0;
                        if (bus.play_in) begin
                            req_d = 1'b1;
                            sh_d  = frame_c;
                            sdo_d = I2S_STD ? sh[SH_W-1] : frame_c[SH_W-1];
                        end else if (I2S_STD) begin
                            state_d = TAIL;
                            sdo_d   = sh[SH_W-1];
                        end else begin
                            state_d = STOP;
                            sdo_d   = 1'b0;
                        end
                    end else begin
                        bcnt_d = bcnt_inc_c;
                        sdo_d  = sh[SH_W-1];
                        ws_d   = (bcnt_inc_c >= RIGHT_BIT);
                    end
                end
            end
            TAIL: begin
                if (fall_c) begin
                    state_d = STOP;
                    sdo_d   = 1'b0;
                end
            end
            default: state_d = STOP;
        endcase
    end

    // Datapath registers
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            bcnt <= '0;
            smp  <= '0;
            sh   <= '0;
            rate <= 2'b00;
            sdo  <= 1'b0;
            ws   <= 1'b0;
            req  <= 1'b0;
        end else begin
            bcnt <= bcnt_d;
            smp  <= smp_d;
            sh   <= sh_d;
            rate <= rate_d;
            sdo  <= sdo_d;
            ws   <= ws_d;
            req  <= req_d;
        end
    end

    assign bus.req_out = req;
    assign bus.sck_out = sck;
    assign bus.ws_out  = ws;
    assign bus.sdo_out = sdo;

endmodule
